// File: rtl/response_arbiter_pkg.sv
// Shared types for the messaging-unit response return path.
// Holds the response payload layout and the response source encoding.
package response_arbiter_pkg;

  typedef struct packed {
    logic [4:0]  register;
    logic [31:0] value;
  } response_data_t;

  typedef enum logic {
    RESPONSE_SOURCE_SEND = 1'b0,
    RESPONSE_SOURCE_RECV = 1'b1
  } response_source_t;

  // Writes to x0 complete their handshake but never reach writeback.
  function automatic logic needs_writeback(input response_data_t d);
    return d.register != 5'd0;
  endfunction

endpackage

// File: rtl/response_fifo.sv
// In-order response buffer of DEPTH entries with head/tail pointers
// wrapping modulo DEPTH and a registered occupancy count.
module response_fifo
  import response_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  response_data_t               push_data,
  input  logic                         pop,
  output response_data_t               head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  response_data_t mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic           empty;
  logic           do_push;
  logic           do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= push_data;
        tail      <= next_ptr(tail);
      end
      if (do_pop) head <= next_ptr(head);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/response_arbiter.sv
// Merges send/receive pipeline responses into one writeback stream.
// XCTCMSG_RESPONSE_ARBITER_RR_EN selects round-robin; otherwise receive has fixed priority.
module response_arbiter
  import response_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           send_response_arbiter_valid,
  output logic           response_arbiter_send_ready,
  input  response_data_t send_response_arbiter_data,
  input  logic           receive_response_arbiter_valid,
  output logic           response_arbiter_receive_ready,
  input  response_data_t receive_response_arbiter_data,
  output logic           response_arbiter_wb_valid,
  input  logic           wb_response_arbiter_ready,
  output response_data_t response_arbiter_wb_data
);

  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       full;
  logic                       send_grant;
  logic                       recv_grant;
  response_source_t           grant_src;
  response_data_t             grant_data;
  logic                       push;
  logic                       pop;

`ifdef XCTCMSG_RESPONSE_ARBITER_RR_EN
  logic prefer_receive;

  assign response_arbiter_send_ready =
    ~full & ~(receive_response_arbiter_valid & prefer_receive);
  assign response_arbiter_receive_ready =
    ~full & ~(send_response_arbiter_valid & ~prefer_receive);

  // The loser of each grant gets preference next time; idle cycles keep it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefer_receive <= 1'b0;
    end else if (send_grant | recv_grant) begin
      prefer_receive <= (grant_src == RESPONSE_SOURCE_SEND);
    end
  end
`else
  assign response_arbiter_send_ready    = ~full & ~receive_response_arbiter_valid;
  assign response_arbiter_receive_ready = ~full;
`endif

  assign send_grant = send_response_arbiter_valid & response_arbiter_send_ready;
  assign recv_grant = receive_response_arbiter_valid & response_arbiter_receive_ready;
  assign grant_src  = recv_grant ? RESPONSE_SOURCE_RECV : RESPONSE_SOURCE_SEND;
  assign grant_data = recv_grant ? receive_response_arbiter_data : send_response_arbiter_data;
  assign push       = (send_grant | recv_grant) & needs_writeback(grant_data);

  assign response_arbiter_wb_valid = (count != '0);
  assign pop = response_arbiter_wb_valid & wb_response_arbiter_ready;

  response_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(grant_data),
    .pop      (pop),
    .head_data(response_arbiter_wb_data),
    .count    (count),
    .full     (full)
  );

endmodule

// File: tb/tb_response_arbiter.sv
// Bench for response_arbiter: vector table plus reset sequence, with a
// response queue holding the expected writeback order.
module tb_response_arbiter;
  import response_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           send_valid;
  logic           send_ready;
  response_data_t send_data;
  logic           recv_valid;
  logic           recv_ready;
  response_data_t recv_data;
  logic           wb_valid;
  logic           wb_ready;
  response_data_t wb_data;

  always #5 clk = ~clk;

  response_arbiter #(.DEPTH(DEPTH)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .send_response_arbiter_valid    (send_valid),
    .response_arbiter_send_ready    (send_ready),
    .send_response_arbiter_data     (send_data),
    .receive_response_arbiter_valid (recv_valid),
    .response_arbiter_receive_ready (recv_ready),
    .receive_response_arbiter_data  (recv_data),
    .response_arbiter_wb_valid      (wb_valid),
    .wb_response_arbiter_ready      (wb_ready),
    .response_arbiter_wb_data       (wb_data)
  );

  typedef struct {
    logic        sv;
    logic [4:0]  sreg;
    logic [31:0] sval;
    logic        rv;
    logic [4:0]  rreg;
    logic [31:0] rval;
    logic        wbr;
    logic        exp_wv;
  } vec_t;

  vec_t           vecs[$];
  response_data_t exp_q[$];
  bit             pref_recv;
  int             errors = 0;
  int             checks = 0;

  function automatic vec_t mk(logic sv, logic [4:0] sreg, logic [31:0] sval,
                              logic rv, logic [4:0] rreg, logic [31:0] rval,
                              logic wbr, logic exp_wv);
    vec_t v;
    v.sv = sv; v.sreg = sreg; v.sval = sval;
    v.rv = rv; v.rreg = rreg; v.rval = rval;
    v.wbr = wbr; v.exp_wv = exp_wv;
    return v;
  endfunction

  task automatic chk_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_data(string name, response_data_t act, response_data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got reg=%0d val=%h expected reg=%0d val=%h at %0t",
               name, act.register, act.value, exp.register, exp.value, $time);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    logic full_m, esr, err, sg, rg;
    send_valid = v.sv; send_data = '{register: v.sreg, value: v.sval};
    recv_valid = v.rv; recv_data = '{register: v.rreg, value: v.rval};
    wb_ready   = v.wbr;
    #2;
    full_m = (exp_q.size() == DEPTH);
`ifdef XCTCMSG_RESPONSE_ARBITER_RR_EN
    esr = !full_m && !(v.rv && pref_recv);
    err = !full_m && !(v.sv && !pref_recv);
`else
    esr = !full_m && !v.rv;
    err = !full_m;
`endif
    chk_bit($sformatf("send_ready[%0d]", idx), send_ready, esr);
    chk_bit($sformatf("recv_ready[%0d]", idx), recv_ready, err);
    chk_bit($sformatf("wb_valid[%0d]", idx), wb_valid, v.exp_wv);
    if (exp_q.size() != 0) chk_data($sformatf("wb_data[%0d]", idx), wb_data, exp_q[0]);
    sg = v.sv && esr;
    rg = v.rv && err;
    if (exp_q.size() != 0 && v.wbr) void'(exp_q.pop_front());
    if (sg) begin
      if (v.sreg != 0) exp_q.push_back('{register: v.sreg, value: v.sval});
      pref_recv = 1'b1;
    end else if (rg) begin
      if (v.rreg != 0) exp_q.push_back('{register: v.rreg, value: v.rval});
      pref_recv = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    send_valid = 1'b0; send_data = '0;
    recv_valid = 1'b0; recv_data = '0;
    wb_ready = 1'b0;
    pref_recv = 1'b0;

    // Conflict every cycle right after reset, writeback always ready.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, (i != 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    // Single send, one-cycle latency, then drained.
    vecs.push_back(mk(1, 5'd5, 32'h1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    // Receive write to x0, then a conflict.
    vecs.push_back(mk(0, 0, 0, 1, 5'd0, 32'hDEAD, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 5'd8, 32'h88, 1, 5'd9, 32'h99, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    // Fill with writeback stalled, release for one cycle, refill.
    vecs.push_back(mk(1, 5'd3, 32'h33, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5'd4, 32'h44, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 5'd6, 32'h66, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 5'd6, 32'h66, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 5'd6, 32'h66, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 5'd10, 32'hAA, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 5'd10, 32'hAA, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 5'd10, 32'hAA, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));

    #1;
    chk_bit("in_reset_wb_valid", wb_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_bit("reset_wb_valid", wb_valid, 1'b0);
    chk_data("reset_wb_data", wb_data, '0);
    chk_bit("reset_send_ready", send_ready, 1'b1);
    chk_bit("reset_recv_ready", recv_ready, 1'b1);

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset with two entries buffered.
    apply(mk(1, 5'd11, 32'hB1, 0, 0, 0, 0, 0), 100);
    apply(mk(1, 5'd12, 32'hB2, 0, 0, 0, 0, 1), 101);
    send_valid = 1'b0; recv_valid = 1'b0; wb_ready = 1'b0;
    #1;
    chk_bit("pre_rst_wb_valid", wb_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk_bit("mid_rst_wb_valid", wb_valid, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_bit("post_rst_send_ready", send_ready, 1'b1);
    chk_bit("post_rst_recv_ready", recv_ready, 1'b1);
    chk_bit("post_rst_wb_valid", wb_valid, 1'b0);
    exp_q.delete();
    pref_recv = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0), 102);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0), 103);
    apply(mk(1, 5'd13, 32'hC3, 0, 0, 0, 1, 0), 104);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 1), 105);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0), 106);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses left expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/response_arbiter.md
# response_arbiter

Return path of the messaging unit: collects completion responses from the send pipeline and the receive pipeline and delivers them, one per cycle, to the core's writeback stage. Each response names a destination register and a 32-bit result value. The block arbitrates between the two pipelines, buffers accepted responses in a small in-order FIFO, and drops writes to x0. It is the inverse end of the request path that splits RR-stage requests into the send and receive queues.

## Interface
Parameters:
- DEPTH, 2, number of buffered responses; legal values are ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- send_response_arbiter_valid  in  1  send pipeline presents a response.
- response_arbiter_send_ready  out  1  send response is accepted when valid and ready are both high.
- send_response_arbiter_data  in  response_data_t  fields register[4:0] and value[31:0].
- receive_response_arbiter_valid  in  1  receive pipeline presents a response.
- response_arbiter_receive_ready  out  1  receive response is accepted when valid and ready are both high.
- receive_response_arbiter_data  in  response_data_t  same fields.
- response_arbiter_wb_valid  out  1  head entry is available to writeback.
- wb_response_arbiter_ready  in  1  writeback consumes the head entry.
- response_arbiter_wb_data  out  response_data_t  head entry.

## Operation
- Occupancy `count` is 0..DEPTH, $clog2(DEPTH+1) bits wide. `full` means count==DEPTH.
- Preference flop `prefer_receive` resets to 0, so send wins the first conflict.
- response_arbiter_send_ready = !full & !(receive_valid & prefer_receive).
- response_arbiter_receive_ready = !full & !(send_valid & !prefer_receive).
- At most one input is granted per cycle (grant = valid & ready).
- On every grant, `prefer_receive` is set to the opposite of the granted source. It is unchanged in cycles with no grant.
- A granted response with register==0 is accepted (handshake completes) but not enqueued. It still updates `prefer_receive`.
- A granted response with register!=0 is written at the tail pointer.
- Head and tail pointers wrap modulo DEPTH.
- response_arbiter_wb_valid = (count!=0). response_arbiter_wb_data is the entry at the head.
- A dequeue occurs when wb_valid & wb_ready; the head then advances.
- Enqueue and dequeue may happen in the same cycle; count is unchanged.
- Input readiness depends only on registered `full`. There is no same-cycle pass-through, and a dequeue does not free a slot until the next cycle.
- FIFO order is strict; no reordering between sources.

## Timing
- Reset values: count=0, head=0, tail=0, prefer_receive=0, all storage=0.
- After reset: wb_valid=0, wb_data=0, both input readies=1 (the block is not full).
- Reset asserted mid-operation discards all buffered entries immediately (asynchronous), with wb_valid falling combinationally with rst.
- Latency: a response accepted in cycle N is visible at the output in cycle N+1 when the FIFO was empty.
- Throughput: one response per cycle with wb_ready held high.
- Full with wb_ready=1: both readies are low in that cycle; accepting resumes in the next cycle.
- Empty: wb_valid=0, and wb_data holds the stale head content.
- A valid deasserted without ready is not a protocol violation. The source must hold its data stable while valid is high and ready is low.

## Configuration
- XCTCMSG_RESPONSE_ARBITER_RR_EN defined: round-robin arbitration as described above, using the `prefer_receive` flop.
- Macro undefined: fixed priority, receive always over send.
  - `prefer_receive` is removed.
  - response_arbiter_send_ready = !full & !receive_valid.
  - response_arbiter_receive_ready = !full.

## Structure
- response_data_t (register[4:0], value[31:0]) goes in xctcmsg_defs.svh alongside request_data_t and the queue data types.
- The response source enum {RESPONSE_SOURCE_SEND, RESPONSE_SOURCE_RECV} also goes in the shared package.
- One sub-module, response_fifo: the parameterized DEPTH FIFO with push/pop, count, full/empty.
- Arbitration, the x0 filter and the preference flop stay in response_arbiter.

## Test plan
- Reset then single send {reg 5, 0x1}: accepted cycle 1; wb_valid=1 with {5,0x1} in cycle 2; wb_valid=0 after pop.
- Both sources valid every cycle (send reg 1, recv reg 2), wb_ready=1, RR_EN defined: output order 1,2,1,2 with send first. With the macro undefined, order is 2,2,2 and the send ready stays 0.
- wb_ready=0, three sends with DEPTH=2: the first two are accepted and send ready falls to 0. Raising wb_ready pops the first entry, and the third send is accepted one cycle later. Output order is preserved.
- Receive response with reg 0 and value 0xDEAD: handshake completes, count stays 0, wb_valid stays 0, next conflict is granted to send.
- Full FIFO with wb_ready=1 and send valid: no accept that cycle, accept in the next cycle, count back at DEPTH.
- rst pulsed while count=2: wb_valid drops during reset; after release count=0, readies=1, no stale entries emerge.
